// File: rtl/nd_4to1_rr.sv
// nd_4to1_rr: four 4-phase request/acknowledge inputs merged round-robin into one
// output channel through a small message FIFO.
module nd_4to1_rr #(
    parameter int FSZ = 4,
    parameter int ASZ = 8,
    parameter int DSZ = 8
) (
    input  logic                 i_clk,
    input  logic                 reset,
    output logic                 ready,
    input  logic [ASZ-1:0]       rcv0_src,
    input  logic [ASZ-1:0]       rcv0_dst,
    input  logic [DSZ-1:0]       rcv0_dat,
    input  logic                 rcv0_req,
    output logic                 rcv0_ack,
    input  logic [ASZ-1:0]       rcv1_src,
    input  logic [ASZ-1:0]       rcv1_dst,
    input  logic [DSZ-1:0]       rcv1_dat,
    input  logic                 rcv1_req,
    output logic                 rcv1_ack,
    input  logic [ASZ-1:0]       rcv2_src,
    input  logic [ASZ-1:0]       rcv2_dst,
    input  logic [DSZ-1:0]       rcv2_dat,
    input  logic                 rcv2_req,
    output logic                 rcv2_ack,
    input  logic [ASZ-1:0]       rcv3_src,
    input  logic [ASZ-1:0]       rcv3_dst,
    input  logic [DSZ-1:0]       rcv3_dat,
    input  logic                 rcv3_req,
    output logic                 rcv3_ack,
    output logic [ASZ-1:0]       snd0_src,
    output logic [ASZ-1:0]       snd0_dst,
    output logic [DSZ-1:0]       snd0_dat,
    output logic                 snd0_req,
    input  logic                 snd0_ack,
    output logic [1:0]           dbg_state,
    output logic [$clog2(FSZ):0] dbg_count
);
    localparam int PW = $clog2(FSZ);
    localparam int MW = 2 * ASZ + DSZ;
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(FSZ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DROP = 2'd2
    } state_t;

    // Every channel is 4-phase: sender raises req with the message stable, receiver
    // captures and raises ack, sender drops req, receiver drops ack; a new req may
    // only be raised once ack is seen low.
    logic [MW-1:0] rcv_msg [4];
    logic [3:0]    rcv_req;
    logic [3:0]    rcv_ack;

    assign rcv_msg[0] = {rcv0_src, rcv0_dst, rcv0_dat};
    assign rcv_msg[1] = {rcv1_src, rcv1_dst, rcv1_dat};
    assign rcv_msg[2] = {rcv2_src, rcv2_dst, rcv2_dat};
    assign rcv_msg[3] = {rcv3_src, rcv3_dst, rcv3_dat};
    assign rcv_req    = {rcv3_req, rcv2_req, rcv1_req, rcv0_req};
    assign rcv0_ack   = rcv_ack[0];
    assign rcv1_ack   = rcv_ack[1];
    assign rcv2_ack   = rcv_ack[2];
    assign rcv3_ack   = rcv_ack[3];

    logic [MW-1:0] mem [FSZ];
    logic [MW-1:0] snd_msg;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;
    logic [1:0]    ptr;
    state_t        state;
    state_t        state_nxt;
    logic          req_nxt;
    logic          pop;
    logic [3:0]    pend;
    logic          found;
    logic          grant;
    logic [1:0]    gidx;
    logic [1:0]    cand;

    assign {snd0_src, snd0_dst, snd0_dat} = snd_msg;
    assign dbg_state = state;
    assign dbg_count = count;

    // Round-robin scan starting at ptr; fullness is judged before this edge's pop.
    always_comb begin
        pend  = rcv_req & ~rcv_ack;
        found = 1'b0;
        gidx  = ptr;
        cand  = ptr;
        for (int i = 0; i < 4; i++) begin
            cand = ptr + 2'(i);
            if (!found && pend[cand]) begin
                found = 1'b1;
                gidx  = cand;
            end
        end
        grant = ready && found && (count < FULL_CNT);
    end

    always_comb begin
        state_nxt = state;
        req_nxt   = snd0_req;
        pop       = 1'b0;
        unique case (state)
            S_IDLE: if (ready && count != '0) begin
                pop       = 1'b1;
                req_nxt   = 1'b1;
                state_nxt = S_SEND;
            end
            S_SEND: if (snd0_ack) begin
                req_nxt   = 1'b0;
                state_nxt = S_DROP;
            end
            S_DROP: if (!snd0_ack) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            ready    <= 1'b0;
            rcv_ack  <= '0;
            ptr      <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            state    <= S_IDLE;
            snd0_req <= 1'b0;
            snd_msg  <= '0;
        end else begin
            ready    <= 1'b1;
            state    <= state_nxt;
            snd0_req <= req_nxt;
            for (int k = 0; k < 4; k++) begin
                if (grant && gidx == 2'(k))
                    rcv_ack[k] <= 1'b1;
                else if (rcv_ack[k] && !rcv_req[k])
                    rcv_ack[k] <= 1'b0;
            end
            if (grant) begin
                head <= head + PW'(1);
                ptr  <= gidx + 2'd1;
            end
            if (pop) begin
                tail    <= tail + PW'(1);
                snd_msg <= mem[tail];
            end
            case ({grant, pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked entirely by count/head/tail.
    always_ff @(posedge i_clk) begin
        if (grant) mem[head] <= rcv_msg[gidx];
    end
endmodule

// File: tb/tb_nd_4to1_rr.sv
// Directed bench for nd_4to1_rr: reset, single path, round-robin fairness, full FIFO,
// simultaneous push/pop and asynchronous reset mid-transfer.
module tb_nd_4to1_rr;
    localparam int FSZ = 4;
    localparam int ASZ = 8;
    localparam int DSZ = 8;
    localparam int MW  = 2 * ASZ + DSZ;

    logic           i_clk = 1'b0;
    logic           reset;
    logic           ready;
    logic [ASZ-1:0] r_src [4];
    logic [ASZ-1:0] r_dst [4];
    logic [DSZ-1:0] r_dat [4];
    logic [3:0]     r_req;
    logic [3:0]     r_ack;
    logic [ASZ-1:0] snd0_src;
    logic [ASZ-1:0] snd0_dst;
    logic [DSZ-1:0] snd0_dat;
    logic           snd0_req;
    logic           snd0_ack;
    logic [1:0]     dbg_state;
    logic [2:0]     dbg_count;
    logic [MW-1:0]  snd_msg;

    int n_tests = 0;
    int n_fail  = 0;

    assign snd_msg = {snd0_src, snd0_dst, snd0_dat};

    always #5 i_clk = ~i_clk;

    nd_4to1_rr #(.FSZ(FSZ), .ASZ(ASZ), .DSZ(DSZ)) dut (
        .i_clk(i_clk), .reset(reset), .ready(ready),
        .rcv0_src(r_src[0]), .rcv0_dst(r_dst[0]), .rcv0_dat(r_dat[0]), .rcv0_req(r_req[0]), .rcv0_ack(r_ack[0]),
        .rcv1_src(r_src[1]), .rcv1_dst(r_dst[1]), .rcv1_dat(r_dat[1]), .rcv1_req(r_req[1]), .rcv1_ack(r_ack[1]),
        .rcv2_src(r_src[2]), .rcv2_dst(r_dst[2]), .rcv2_dat(r_dat[2]), .rcv2_req(r_req[2]), .rcv2_ack(r_ack[2]),
        .rcv3_src(r_src[3]), .rcv3_dst(r_dst[3]), .rcv3_dat(r_dat[3]), .rcv3_req(r_req[3]), .rcv3_ack(r_ack[3]),
        .snd0_src(snd0_src), .snd0_dst(snd0_dst), .snd0_dat(snd0_dat),
        .snd0_req(snd0_req), .snd0_ack(snd0_ack),
        .dbg_state(dbg_state), .dbg_count(dbg_count)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [MW-1:0] mk(input int k, input logic [7:0] d);
        return {8'(k), ~d, d};
    endfunction

    task automatic put(input int k, input logic [MW-1:0] m);
        {r_src[k], r_dst[k], r_dat[k]} = m;
        r_req[k] = 1'b1;
    endtask

    // Full round trip through an empty, idle block.
    task automatic xfer(input int k, input logic [MW-1:0] m);
        put(k, m);
        tick; chk("xfer_ack_hi", 32'(r_ack[k]), 1); chk("xfer_no_early_req", 32'(snd0_req), 0);
        r_req[k] = 1'b0;
        tick; chk("xfer_ack_lo", 32'(r_ack[k]), 0); chk("xfer_snd_req", 32'(snd0_req), 1);
        chk("xfer_msg", 32'(snd_msg), 32'(m));
        snd0_ack = 1'b1;
        tick; chk("xfer_req_drop", 32'(snd0_req), 0);
        snd0_ack = 1'b0;
        tick; chk("xfer_idle", 32'(dbg_state), 0);
    endtask

    task automatic push_one(input int k, input logic [MW-1:0] m);
        put(k, m);
        tick; chk("push_ack", 32'(r_ack[k]), 1);
        r_req[k] = 1'b0;
        tick;
    endtask

    task automatic drain_one(input logic [MW-1:0] m);
        for (int w = 0; w < 8 && !snd0_req; w++) tick;
        chk("drain_req", 32'(snd0_req), 1);
        chk("drain_msg", 32'(snd_msg), 32'(m));
        snd0_ack = 1'b1;
        tick; chk("drain_req_drop", 32'(snd0_req), 0);
        snd0_ack = 1'b0;
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [MW-1:0] exp_q [$];
        logic [MW-1:0] fm [6];
        logic [MW-1:0] em;
        logic [3:0]    prev_ack;
        logic          prev_sreq;
        logic          got;
        logic          done;
        int            sent [4];
        int            gcnt [4];
        int            ngrant;
        int            nout;
        int            cyc;
        int            acks;

        reset    = 1'b0;
        snd0_ack = 1'b0;
        r_req    = '0;
        for (int k = 0; k < 4; k++) {r_src[k], r_dst[k], r_dat[k]} = '0;

        // Reset: rcv0 already requesting, must be ignored until after ready rises.
        put(0, mk(0, 8'hA5));
        for (int c = 0; c < 3; c++) begin
            tick;
            chk("rst_ready", 32'(ready), 0);
            chk("rst_acks", 32'(r_ack), 0);
            chk("rst_snd_req", 32'(snd0_req), 0);
        end
        reset = 1'b1;
        tick;
        chk("init_ready", 32'(ready), 1);
        chk("init_no_ack", 32'(r_ack), 0);
        xfer(0, mk(0, 8'hA5));

        // Single path 1/5/9 on rcv2, then rcv3 so the pointer returns to 0.
        xfer(2, {8'd1, 8'd5, 8'd9});
        xfer(3, mk(3, 8'h3C));

        // Fairness: all four request continuously, 4 messages each.
        ngrant = 0; nout = 0; cyc = 0; done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            gcnt[k] = 0;
            put(k, mk(k, 8'(16 * k)));
            sent[k] = 1;
        end
        prev_ack  = r_ack;
        prev_sreq = snd0_req;
        while (cyc < 400 && !done) begin
            tick;
            cyc++;
            for (int k = 0; k < 4; k++) begin
                if (r_ack[k] && !prev_ack[k]) begin
                    chk("rr_order", 32'(k), 32'(ngrant % 4));
                    ngrant++;
                    gcnt[k]++;
                    exp_q.push_back({r_src[k], r_dst[k], r_dat[k]});
                end
            end
            if (snd0_req && !prev_sreq) begin
                chk("rr_out_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    em = exp_q.pop_front();
                    chk("rr_out_msg", 32'(snd_msg), 32'(em));
                end
                nout++;
            end
            prev_ack  = r_ack;
            prev_sreq = snd0_req;
            if (snd0_req && !snd0_ack) snd0_ack = 1'b1;
            else if (!snd0_req && snd0_ack) snd0_ack = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (r_req[k] && r_ack[k]) r_req[k] = 1'b0;
                else if (!r_req[k] && !r_ack[k] && sent[k] < 4) begin
                    put(k, mk(k, 8'(16 * k + sent[k])));
                    sent[k]++;
                end
            end
            done = (nout == 16) && (dbg_state == 2'd0) && !snd0_req && !snd0_ack
                   && (r_req == 4'd0) && (r_ack == 4'd0);
        end
        chk("rr_finished", 32'(done), 1);
        chk("rr_grants", 32'(ngrant), 16);
        chk("rr_outputs", 32'(nout), 16);
        for (int k = 0; k < 4; k++) chk("rr_per_input", 32'(gcnt[k]), 4);
        chk("rr_fifo_empty", 32'(dbg_count), 0);

        // Full FIFO: downstream never acks, 6 messages offered on rcv0.
        acks = 0;
        for (int m = 0; m < 6; m++) begin
            fm[m] = mk(0, 8'(8'h60 + m));
            put(0, fm[m]);
            got = 1'b0;
            for (int w = 0; w < 3 && !got; w++) begin
                tick;
                got = r_ack[0];
            end
            if (got) begin
                acks++;
                r_req[0] = 1'b0;
                tick;
            end
        end
        chk("full_acks", 32'(acks), 5);
        chk("full_count", 32'(dbg_count), 4);
        chk("full_6th_unacked", 32'(r_ack[0]), 0);
        chk("full_inflight_req", 32'(snd0_req), 1);
        chk("full_inflight_msg", 32'(snd_msg), 32'(fm[0]));
        snd0_ack = 1'b1;
        tick; chk("full_req_drop", 32'(snd0_req), 0);
        snd0_ack = 1'b0;
        tick; chk("full_still_unacked", 32'(r_ack[0]), 0);
        tick;
        chk("full_pop_no_slot", 32'(r_ack[0]), 0);
        chk("full_pop_msg", 32'(snd_msg), 32'(fm[1]));
        chk("full_pop_count", 32'(dbg_count), 3);
        tick;
        chk("full_6th_acked", 32'(r_ack[0]), 1);
        chk("full_refill", 32'(dbg_count), 4);
        r_req[0] = 1'b0;
        for (int m = 1; m < 6; m++) drain_one(fm[m]);
        chk("full_drained", 32'(dbg_count), 0);

        // Simultaneous push and pop with count=2 in IDLE.
        push_one(1, mk(1, 8'hB0));
        chk("sim_a_loaded", 32'(snd_msg), 32'(mk(1, 8'hB0)));
        push_one(1, mk(1, 8'hB1));
        push_one(1, mk(1, 8'hB2));
        chk("sim_count_pre", 32'(dbg_count), 2);
        snd0_ack = 1'b1;
        tick;
        snd0_ack = 1'b0;
        tick;
        chk("sim_idle", 32'(dbg_state), 0);
        chk("sim_count_idle", 32'(dbg_count), 2);
        put(2, mk(2, 8'hB3));
        tick;
        chk("sim_count_same", 32'(dbg_count), 2);
        chk("sim_push_ack", 32'(r_ack[2]), 1);
        chk("sim_pop_msg", 32'(snd_msg), 32'(mk(1, 8'hB1)));
        r_req[2] = 1'b0;
        drain_one(mk(1, 8'hB1));
        drain_one(mk(1, 8'hB2));
        drain_one(mk(2, 8'hB3));

        // Asynchronous reset while snd0_req=1 and count=3.
        push_one(0, mk(0, 8'hC0));
        push_one(1, mk(1, 8'hC1));
        push_one(2, mk(2, 8'hC2));
        push_one(3, mk(3, 8'hC3));
        chk("ar_count", 32'(dbg_count), 3);
        chk("ar_req_before", 32'(snd0_req), 1);
        #3;
        reset = 1'b0;
        #1;
        chk("ar_req_now", 32'(snd0_req), 0);
        chk("ar_ready_now", 32'(ready), 0);
        chk("ar_count_now", 32'(dbg_count), 0);
        chk("ar_msg_now", 32'(snd_msg), 0);
        tick;
        reset = 1'b1;
        tick;
        chk("ar_reinit", 32'(ready), 1);
        for (int c = 0; c < 6; c++) begin
            tick;
            chk("ar_no_stale", 32'(snd0_req), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
